// File: rtl/uart_rx.sv
// 8/N/1 UART receiver with a 2-flop input synchronizer, mid-bit sampling,
// and a one-entry output buffer using a valid/ready handshake.
module uart_rx #(
  parameter int CLK_FREQ = 250000,
  parameter int BAUD     = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic          sync_q, rx_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          byte_done;

  assign tick = (cnt_q == '0);

  // State register and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sync_q  <= 1'b1;
      rx_q    <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= i_in;
      rx_q    <= sync_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: bit timing counter, bit index and shift register follow the FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_q) begin
          state_d = S_START;
          cnt_d   = CW'(HALF_BIT - 1);
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_q) begin
            state_d = S_DATA;
            cnt_d   = CW'(CLKS_PER_BIT - 1);
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d[idx_q] = rx_q;
          cnt_d          = CW'(CLKS_PER_BIT - 1);
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick) state_d = rx_q ? S_IDLE : S_WAIT_HIGH;
        else      cnt_d   = cnt_q - CW'(1);
      end
      S_WAIT_HIGH: begin
        if (rx_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: a completed byte either lands in the buffer or is reported as overrun
  always_comb begin
    byte_done = (state_q == S_STOP) && tick && rx_q;
    ferr_d    = (state_q == S_STOP) && tick && !rx_q;
    ovr_d     = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (byte_done) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences, and randomized frames checked against a queue-based reference.
module tb_uart_rx;

  localparam int CLK_FREQ = 250000;
  localparam int BAUD     = 9600;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, ovr;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in       (rx_line),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(ferr),
    .o_overrun  (ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge: o_valid rises, frame errors, overruns
  logic       valid_prev = 1'b0;
  int         valid_hi = 0;
  logic [7:0] mon_data[$];
  int         mon_vcyc[$];
  int         mon_ferr[$];
  int         mon_ovr[$];

  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      mon_data.push_back(data);
      mon_vcyc.push_back(cyc);
    end
    if (valid) valid_hi <= valid_hi + 1;
    if (ferr) mon_ferr.push_back(cyc);
    if (ovr)  mon_ovr.push_back(cyc);
    valid_prev <= valid;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, got, got);
    end
  endtask

  // Called at a rising edge; returns at a rising edge. start = edges seen before the start bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int start);
    #1 rx_line = 1'b0;
    start = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_line = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_line = stop_ok;
    repeat (CPB) @(posedge clk);
    if (!stop_ok) begin
      #1 rx_line = 1'b1;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    #1 rx_line = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_nvalid;
    logic [7:0] exp_data;
    int         exp_nferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s1, s2, bv, bf, bo, bh;
    logic [7:0] exp_q[$];
    int         exp_c[$];
    int         exp_ferr;

    vecs[0] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
    vecs[1] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[2] = '{8'h55, 1'b0, 0, 8'h00, 1};
    vecs[3] = '{8'h0F, 1'b1, 1, 8'h0F, 0};
    vecs[4] = '{8'hC3, 1'b1, 1, 8'hC3, 0};

    // Reset values
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset o_data", data, 0);
    check("reset o_valid", valid, 0);
    check("reset o_frame_err", ferr, 0);
    check("reset o_overrun", ovr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    idle(10);

    // Short low glitch on an idle line is rejected silently
    bv = mon_data.size(); bf = mon_ferr.size();
    #1 rx_line = 1'b0;
    repeat (5) @(posedge clk);
    idle(60);
    check("glitch no valid", mon_data.size() - bv, 0);
    check("glitch no ferr", mon_ferr.size() - bf, 0);

    // Table-driven frames with i_ready held high
    foreach (vecs[k]) begin
      bv = mon_data.size(); bf = mon_ferr.size(); bh = valid_hi;
      send_frame(vecs[k].data, vecs[k].stop_ok, s);
      idle(30);
      check($sformatf("vec%0d valid count", k), mon_data.size() - bv, vecs[k].exp_nvalid);
      check($sformatf("vec%0d valid cycles", k), valid_hi - bh, vecs[k].exp_nvalid);
      check($sformatf("vec%0d ferr count", k), mon_ferr.size() - bf, vecs[k].exp_nferr);
      if (vecs[k].exp_nvalid > 0 && mon_data.size() > bv) begin
        check($sformatf("vec%0d data", k), mon_data[bv], vecs[k].exp_data);
        check($sformatf("vec%0d latency", k), mon_vcyc[bv] - s, LAT);
      end
      if (vecs[k].exp_nferr > 0 && mon_ferr.size() > bf)
        check($sformatf("vec%0d ferr latency", k), mon_ferr[bf] - s, LAT);
    end

    // Overrun: consumer stalled, second byte dropped
    bv = mon_data.size(); bo = mon_ovr.size();
    #1 ready = 1'b0;
    send_frame(8'h11, 1'b1, s1);
    send_frame(8'h22, 1'b1, s2);
    idle(10);
    check("ovr valid count", mon_data.size() - bv, 1);
    if (mon_data.size() > bv) check("ovr first data", mon_data[bv], 8'h11);
    check("ovr pulse count", mon_ovr.size() - bo, 1);
    if (mon_ovr.size() > bo) check("ovr pulse time", mon_ovr[bo] - s2, LAT);
    @(negedge clk);
    check("ovr held data", data, 8'h11);
    check("ovr held valid", valid, 1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr valid cleared", valid, 0);
    @(posedge clk);

    // Reset in the middle of bit 4 of 0xFF
    bv = mon_data.size(); bf = mon_ferr.size(); bo = mon_ovr.size();
    #1 rx_line = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 rx_line = 1'b1;
    repeat (4 * CPB + 10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst o_data", data, 0);
    check("midrst o_valid", valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    idle(10);
    send_frame(8'h81, 1'b1, s);
    idle(30);
    check("midrst valid count", mon_data.size() - bv, 1);
    if (mon_data.size() > bv) check("midrst data", mon_data[bv], 8'h81);
    check("midrst no ferr", mon_ferr.size() - bf, 0);
    check("midrst no ovr", mon_ovr.size() - bo, 0);

    // Back-to-back frames, no idle gap
    bv = mon_data.size();
    send_frame(8'h00, 1'b1, s1);
    send_frame(8'hFF, 1'b1, s2);
    idle(30);
    check("b2b valid count", mon_data.size() - bv, 2);
    if (mon_data.size() > bv + 1) begin
      check("b2b data0", mon_data[bv], 8'h00);
      check("b2b data1", mon_data[bv + 1], 8'hFF);
      check("b2b spacing", mon_vcyc[bv + 1] - mon_vcyc[bv], 10 * CPB);
    end

    // Randomized frames against a queue-based reference
    bv = mon_data.size(); bf = mon_ferr.size(); bo = mon_ovr.size();
    exp_ferr = 0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      bit ok;
      int gap;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      gap = $urandom_range(0, 15);
      send_frame(b, ok, s);
      if (ok) begin
        exp_q.push_back(b);
        exp_c.push_back(s + LAT);
      end else begin
        exp_ferr++;
      end
      if (gap > 0) idle(gap);
    end
    idle(30);
    check("rand valid count", mon_data.size() - bv, exp_q.size());
    check("rand ferr count", mon_ferr.size() - bf, exp_ferr);
    check("rand no ovr", mon_ovr.size() - bo, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bv + i < mon_data.size()) begin
        check($sformatf("rand%0d data", i), mon_data[bv + i], exp_q[i]);
        check($sformatf("rand%0d time", i), mon_vcyc[bv + i], exp_c[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
